// File: rtl/branch_pkg.sv
// Shared types for the branch controller and the 2-bit branch history table.
package branch_pkg;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } ctrl_state_t;

    // Saturating counter encoding used by each BHT entry.
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_cnt_t;

    localparam int BR_PC_WIDTH = 32;

    typedef struct packed {
        logic [BR_PC_WIDTH-1:0] pc;
        logic [BR_PC_WIDTH-1:0] target;
        logic                   pred;
    } br_entry_t;

endpackage

// File: rtl/branch_fifo.sv
// Circular queue of in-flight predicted branches, oldest at the head.
module branch_fifo
    import branch_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = br_entry_t,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  T              push_data_i,
    input  logic          pop_i,
    input  logic          clear_i,
    output T              head_o,
    output logic [CW-1:0] count_o
);

    localparam int PW = $clog2(DEPTH);

    T              mem_q [DEPTH];
    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [CW-1:0] count_q;

    // DEPTH is a power of two, so pointer overflow is the wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (clear_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) tail_q <= tail_q + PW'(1);
            if (pop_i)  head_q <= head_q + PW'(1);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !clear_i) mem_q[tail_q] <= push_data_i;
    end

    assign head_o  = mem_q[head_q];
    assign count_o = count_q;

endmodule

// File: rtl/branch_ctrl.sv
// BHT sequencing controller: table clear after reset, in-order branch
// resolution, BHT update strobes and mispredict flush/redirect.
module branch_ctrl
    import branch_pkg::*;
#(
    parameter int PC_WIDTH  = 32,
    parameter int IDX_WIDTH = 8,
    parameter int DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 f_valid,
    input  logic [PC_WIDTH-1:0]  f_pc,
    input  logic [PC_WIDTH-1:0]  f_target,
    input  logic                 f_pred,
    output logic                 f_ready,
    input  logic                 ex_valid,
    input  logic                 ex_taken,
    input  logic [PC_WIDTH-1:0]  ex_target,
    output logic                 flush,
    output logic [PC_WIDTH-1:0]  redirect_pc,
    output logic                 bht_we,
    output logic                 bht_clr,
    output logic [IDX_WIDTH-1:0] bht_idx,
    output logic                 bht_taken,
    output logic                 init_busy,
    output logic                 err_underflow,
    output ctrl_state_t          dbg_state
);

    localparam int                   CW       = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]        DEPTH_C  = CW'(DEPTH);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = '1;

    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic [PC_WIDTH-1:0] target;
        logic                pred;
    } entry_t;

    ctrl_state_t          state_q, state_d;
    logic [IDX_WIDTH-1:0] init_cnt_q, init_cnt_d;
    logic                 bht_clr_q, bht_clr_d;
    logic [IDX_WIDTH-1:0] bht_idx_q, bht_idx_d;
    logic                 init_busy_q, init_busy_d;
    logic                 bht_we_q, bht_we_d;
    logic                 bht_taken_q, bht_taken_d;
    logic                 flush_q, flush_d;
    logic [PC_WIDTH-1:0]  redirect_q, redirect_d;
    logic                 err_q, err_d;

    entry_t        head;
    entry_t        push_data;
    logic [CW-1:0] count;
    logic          pop;
    logic          mispredict;
    logic          fifo_push;
    logic          fifo_clear;

    assign push_data = '{pc: f_pc, target: f_target, pred: f_pred};
    assign f_ready   = (state_q == RUN) && (count < DEPTH_C);

    branch_fifo #(
        .DEPTH (DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifo_push),
        .push_data_i (push_data),
        .pop_i       (pop && !mispredict),
        .clear_i     (fifo_clear),
        .head_o      (head),
        .count_o     (count)
    );

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        bht_clr_d   = 1'b0;
        bht_idx_d   = bht_idx_q;
        init_busy_d = 1'b0;
        bht_we_d    = 1'b0;
        bht_taken_d = 1'b0;
        flush_d     = 1'b0;
        redirect_d  = redirect_q;
        err_d       = 1'b0;
        pop         = 1'b0;
        mispredict  = 1'b0;
        fifo_push   = 1'b0;
        fifo_clear  = 1'b0;

        case (state_q)
            INIT: begin
                if (init_cnt_q == LAST_IDX) begin
                    state_d = RUN;
                end else begin
                    bht_clr_d   = 1'b1;
                    init_busy_d = 1'b1;
                    init_cnt_d  = init_cnt_q + IDX_WIDTH'(1);
                    bht_idx_d   = init_cnt_q + IDX_WIDTH'(1);
                end
            end
            RUN: begin
                fifo_push = f_valid && f_ready;
                if (ex_valid) begin
                    if (count != '0) begin
                        pop         = 1'b1;
                        bht_we_d    = 1'b1;
                        bht_idx_d   = head.pc[IDX_WIDTH+1:2];
                        bht_taken_d = ex_taken;
                        mispredict  = (ex_taken != head.pred) ||
                                      (ex_taken && head.pred && (ex_target != head.target));
                        // Everything younger than the mispredicted branch is wrong-path.
                        if (mispredict) begin
                            flush_d    = 1'b1;
                            redirect_d = ex_taken ? ex_target : head.pc + PC_WIDTH'(4);
                            fifo_clear = 1'b1;
                            fifo_push  = 1'b0;
                            state_d    = FLUSH;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            FLUSH: begin
                state_d = RUN;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= INIT;
            init_cnt_q  <= '0;
            bht_clr_q   <= 1'b1;
            bht_idx_q   <= '0;
            init_busy_q <= 1'b1;
            bht_we_q    <= 1'b0;
            bht_taken_q <= 1'b0;
            flush_q     <= 1'b0;
            redirect_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            bht_clr_q   <= bht_clr_d;
            bht_idx_q   <= bht_idx_d;
            init_busy_q <= init_busy_d;
            bht_we_q    <= bht_we_d;
            bht_taken_q <= bht_taken_d;
            flush_q     <= flush_d;
            redirect_q  <= redirect_d;
            err_q       <= err_d;
        end
    end

    assign flush         = flush_q;
    assign redirect_pc   = redirect_q;
    assign bht_we        = bht_we_q;
    assign bht_clr       = bht_clr_q;
    assign bht_idx       = bht_idx_q;
    assign bht_taken     = bht_taken_q;
    assign init_busy     = init_busy_q;
    assign err_underflow = err_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Bench for branch_ctrl: directed scenarios plus random traffic against a
// queue-based model of in-order branch resolution.
module tb_branch_ctrl;
    import branch_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        f_valid = 1'b0;
    logic [31:0] f_pc = '0;
    logic [31:0] f_target = '0;
    logic        f_pred = 1'b0;
    logic        f_ready;
    logic        ex_valid = 1'b0;
    logic        ex_taken = 1'b0;
    logic [31:0] ex_target = '0;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        bht_we;
    logic        bht_clr;
    logic [7:0]  bht_idx;
    logic        bht_taken;
    logic        init_busy;
    logic        err_underflow;
    ctrl_state_t dbg_state;

    logic        s_f_ready, s_flush, s_bht_we, s_bht_clr, s_bht_taken, s_init_busy, s_err;
    logic [31:0] s_redirect_pc;
    logic [2:0]  s_bht_idx;
    ctrl_state_t s_dbg_state;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    branch_ctrl #(.PC_WIDTH(32), .IDX_WIDTH(8), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .f_valid(f_valid), .f_pc(f_pc), .f_target(f_target), .f_pred(f_pred), .f_ready(f_ready),
        .ex_valid(ex_valid), .ex_taken(ex_taken), .ex_target(ex_target),
        .flush(flush), .redirect_pc(redirect_pc),
        .bht_we(bht_we), .bht_clr(bht_clr), .bht_idx(bht_idx), .bht_taken(bht_taken),
        .init_busy(init_busy), .err_underflow(err_underflow), .dbg_state(dbg_state)
    );

    branch_ctrl #(.PC_WIDTH(32), .IDX_WIDTH(3), .DEPTH(DEPTH)) dut_small (
        .clk(clk), .rst(rst),
        .f_valid(1'b0), .f_pc(32'd0), .f_target(32'd0), .f_pred(1'b0), .f_ready(s_f_ready),
        .ex_valid(1'b0), .ex_taken(1'b0), .ex_target(32'd0),
        .flush(s_flush), .redirect_pc(s_redirect_pc),
        .bht_we(s_bht_we), .bht_clr(s_bht_clr), .bht_idx(s_bht_idx), .bht_taken(s_bht_taken),
        .init_busy(s_init_busy), .err_underflow(s_err), .dbg_state(s_dbg_state)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] target;
        logic        pred;
    } ent_t;

    typedef struct packed {
        logic        ready;
        logic        we;
        logic        flush;
        logic        err;
        logic [7:0]  idx;
        logic        taken;
        logic [31:0] redir;
    } obs_t;

    ent_t mq[$];
    bit   m_flush = 1'b0;

    // One clock of stimulus from a negedge to the next negedge; the model
    // predicts what the registered outputs must show afterwards.
    task automatic drive_cycle(input logic fv, input logic [31:0] fpc, input logic [31:0] ftgt,
                               input logic fp, input logic exv, input logic ext,
                               input logic [31:0] extg, output obs_t exp_o, output obs_t obs_o);
        ent_t h;
        logic mis;
        exp_o = '0;
        obs_o = '0;
        f_valid = fv; f_pc = fpc; f_target = ftgt; f_pred = fp;
        ex_valid = exv; ex_taken = ext; ex_target = extg;
        #1;
        obs_o.ready = f_ready;
        exp_o.ready = !m_flush && (mq.size() < DEPTH);
        if (m_flush) begin
            m_flush = 1'b0;
        end else if (exv && mq.size() > 0) begin
            h = mq.pop_front();
            exp_o.we    = 1'b1;
            exp_o.idx   = h.pc[9:2];
            exp_o.taken = ext;
            mis = (ext != h.pred) || (ext && h.pred && (extg != h.target));
            if (mis) begin
                exp_o.flush = 1'b1;
                exp_o.redir = ext ? extg : h.pc + 32'd4;
                mq.delete();
                m_flush = 1'b1;
            end else if (fv && exp_o.ready) begin
                mq.push_back('{fpc, ftgt, fp});
            end
        end else begin
            if (exv) exp_o.err = 1'b1;
            if (fv && exp_o.ready) mq.push_back('{fpc, ftgt, fp});
        end
        @(posedge clk);
        @(negedge clk);
        obs_o.we    = bht_we;
        obs_o.flush = flush;
        obs_o.err   = err_underflow;
        obs_o.idx   = bht_idx;
        obs_o.taken = bht_taken;
        obs_o.redir = redirect_pc;
        f_valid = 1'b0; ex_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if ({flush, bht_we, bht_taken, err_underflow, f_ready} !== 5'b0) begin
            errors++; $display("FAIL reset_low got=%b exp=00000", {flush, bht_we, bht_taken, err_underflow, f_ready});
        end
        checks++; if ({bht_clr, init_busy} !== 2'b11 || bht_idx !== 8'd0) begin
            errors++; $display("FAIL reset_init got clr=%b busy=%b idx=%0d exp 1 1 0", bht_clr, init_busy, bht_idx);
        end
        checks++; if (redirect_pc !== 32'd0) begin
            errors++; $display("FAIL reset_redirect got=%h exp=0", redirect_pc);
        end
        checks++; if (dbg_state !== INIT) begin
            errors++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, INIT);
        end
        checks++; if ({s_bht_clr, s_init_busy, s_f_ready} !== 3'b110) begin
            errors++; $display("FAIL reset_small got=%b exp=110", {s_bht_clr, s_init_busy, s_f_ready});
        end
    endtask

    task automatic test_init();
        rst = 1'b0;
        for (int i = 0; i < 256; i++) begin
            checks++; if (bht_clr !== 1'b1 || bht_idx !== 8'(i) || init_busy !== 1'b1 || f_ready !== 1'b0) begin
                errors++; $display("FAIL init_walk i=%0d got clr=%b idx=%0d busy=%b rdy=%b", i, bht_clr, bht_idx, init_busy, f_ready);
            end
            if (i < 8) begin
                checks++; if (s_bht_clr !== 1'b1 || s_bht_idx !== 3'(i) || s_f_ready !== 1'b0) begin
                    errors++; $display("FAIL init_small i=%0d got clr=%b idx=%0d rdy=%b", i, s_bht_clr, s_bht_idx, s_f_ready);
                end
            end else if (i == 8) begin
                checks++; if ({s_bht_clr, s_init_busy, s_f_ready} !== 3'b001) begin
                    errors++; $display("FAIL init_small_done got=%b exp=001", {s_bht_clr, s_init_busy, s_f_ready});
                end
            end
            @(negedge clk);
        end
        checks++; if ({bht_clr, init_busy, f_ready} !== 3'b001) begin
            errors++; $display("FAIL init_done got=%b exp=001", {bht_clr, init_busy, f_ready});
        end
        mq.delete();
        m_flush = 1'b0;
    endtask

    task automatic test_predict_ok();
        obs_t e, o;
        drive_cycle(1'b1, 32'h100, 32'h200, 1'b1, 1'b0, 1'b0, 32'h0, e, o);
        checks++; if (o.ready !== 1'b1 || o.we !== 1'b0) begin
            errors++; $display("FAIL ok_push got rdy=%b we=%b exp 1 0", o.ready, o.we);
        end
        drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h200, e, o);
        checks++; if (o.we !== 1'b1 || o.idx !== 8'h40 || o.taken !== 1'b1 || o.flush !== 1'b0) begin
            errors++; $display("FAIL ok_resolve got we=%b idx=%h tk=%b fl=%b exp 1 40 1 0", o.we, o.idx, o.taken, o.flush);
        end
    endtask

    task automatic test_mispredict_nt();
        obs_t e, o;
        drive_cycle(1'b1, 32'h104, 32'h200, 1'b1, 1'b0, 1'b0, 32'h0, e, o);
        drive_cycle(1'b1, 32'h500, 32'h600, 1'b0, 1'b1, 1'b0, 32'h0, e, o);
        checks++; if (o.flush !== 1'b1 || o.redir !== 32'h108 || o.we !== 1'b1 || o.idx !== 8'h41 || o.taken !== 1'b0) begin
            errors++; $display("FAIL nt_flush got fl=%b pc=%h we=%b idx=%h tk=%b exp 1 108 1 41 0", o.flush, o.redir, o.we, o.idx, o.taken);
        end
        drive_cycle(1'b1, 32'h700, 32'h800, 1'b0, 1'b0, 1'b0, 32'h0, e, o);
        checks++; if (o.ready !== 1'b0 || o.flush !== 1'b0) begin
            errors++; $display("FAIL nt_flush_cycle got rdy=%b fl=%b exp 0 0", o.ready, o.flush);
        end
        drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, e, o);
        checks++; if (o.ready !== 1'b1 || o.err !== 1'b1 || o.we !== 1'b0) begin
            errors++; $display("FAIL nt_queue_empty got rdy=%b err=%b we=%b exp 1 1 0", o.ready, o.err, o.we);
        end
        drive_cycle(1'b1, 32'hFFFF_FFFC, 32'h200, 1'b1, 1'b0, 1'b0, 32'h0, e, o);
        drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, e, o);
        checks++; if (o.flush !== 1'b1 || o.redir !== 32'h0) begin
            errors++; $display("FAIL nt_pc_wrap got fl=%b pc=%h exp 1 0", o.flush, o.redir);
        end
        drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, e, o);
    endtask

    task automatic test_mispredict_target();
        obs_t e, o;
        drive_cycle(1'b1, 32'h10C, 32'h200, 1'b1, 1'b0, 1'b0, 32'h0, e, o);
        drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h300, e, o);
        checks++; if (o.flush !== 1'b1 || o.redir !== 32'h300 || o.idx !== 8'h43 || o.taken !== 1'b1) begin
            errors++; $display("FAIL tgt_flush got fl=%b pc=%h idx=%h tk=%b exp 1 300 43 1", o.flush, o.redir, o.idx, o.taken);
        end
        drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, e, o);
    endtask

    task automatic test_full();
        obs_t e, o;
        for (int k = 1; k <= 4; k++) begin
            drive_cycle(1'b1, 32'(k * 16), 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, e, o);
            checks++; if (o.ready !== 1'b1) begin
                errors++; $display("FAIL full_fill k=%0d got rdy=%b exp 1", k, o.ready);
            end
        end
        drive_cycle(1'b1, 32'h990, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, e, o);
        checks++; if (o.ready !== 1'b0) begin
            errors++; $display("FAIL full_ready got rdy=%b exp 0", o.ready);
        end
        drive_cycle(1'b1, 32'h994, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, e, o);
        checks++; if (o.ready !== 1'b0 || o.we !== 1'b1 || o.idx !== 8'd4 || o.flush !== 1'b0) begin
            errors++; $display("FAIL full_pop_push got rdy=%b we=%b idx=%0d fl=%b exp 0 1 4 0", o.ready, o.we, o.idx, o.flush);
        end
        drive_cycle(1'b1, 32'h50, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, e, o);
        checks++; if (o.ready !== 1'b1 || o.idx !== 8'd8) begin
            errors++; $display("FAIL full_swap got rdy=%b idx=%0d exp 1 8", o.ready, o.idx);
        end
        drive_cycle(1'b1, 32'h60, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, e, o);
        checks++; if (o.ready !== 1'b1) begin
            errors++; $display("FAIL full_refill got rdy=%b exp 1", o.ready);
        end
    endtask

    task automatic test_back_to_back();
        obs_t e, o;
        logic [7:0] want [4];
        want[0] = 8'd12; want[1] = 8'd16; want[2] = 8'd20; want[3] = 8'd24;
        for (int k = 0; k < 4; k++) begin
            drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, e, o);
            checks++; if (o.we !== 1'b1 || o.idx !== want[k] || o.flush !== 1'b0) begin
                errors++; $display("FAIL b2b_order k=%0d got we=%b idx=%0d fl=%b exp 1 %0d 0", k, o.we, o.idx, o.flush, want[k]);
            end
        end
        drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, e, o);
        checks++; if (o.err !== 1'b1 || o.we !== 1'b0) begin
            errors++; $display("FAIL b2b_underflow got err=%b we=%b exp 1 0", o.err, o.we);
        end
    endtask

    task automatic test_random();
        obs_t e, o;
        logic        fv, fp, exv, ext;
        logic [31:0] fpc, ftgt, extg;
        for (int n = 0; n < 400; n++) begin
            fv   = ($urandom_range(0, 3) != 0);
            fpc  = {18'd0, 12'($urandom_range(0, 4095)), 2'b00};
            ftgt = ($urandom_range(0, 1) != 0) ? 32'h200 : 32'h300;
            fp   = 1'($urandom_range(0, 1));
            exv  = ($urandom_range(0, 1) != 0);
            ext  = ($urandom_range(0, 3) != 0) ? ((mq.size() > 0) ? mq[0].pred : 1'b1) : 1'($urandom_range(0, 1));
            extg = (mq.size() > 0 && $urandom_range(0, 3) != 0) ? mq[0].target : 32'h300;
            drive_cycle(fv, fpc, ftgt, fp, exv, ext, extg, e, o);
            checks++; if (o.ready !== e.ready) begin
                errors++; $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, o.ready, e.ready);
            end
            checks++; if ({o.we, o.flush, o.err} !== {e.we, e.flush, e.err}) begin
                errors++; $display("FAIL rnd_strobes n=%0d got we/fl/err=%b exp=%b", n, {o.we, o.flush, o.err}, {e.we, e.flush, e.err});
            end
            if (e.we) begin
                checks++; if (o.idx !== e.idx || o.taken !== e.taken) begin
                    errors++; $display("FAIL rnd_update n=%0d got idx=%h tk=%b exp idx=%h tk=%b", n, o.idx, o.taken, e.idx, e.taken);
                end
            end
            if (e.flush) begin
                checks++; if (o.redir !== e.redir) begin
                    errors++; $display("FAIL rnd_redirect n=%0d got=%h exp=%h", n, o.redir, e.redir);
                end
            end
        end
        repeat (2) drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, e, o);
    endtask

    task automatic test_reset_mid();
        obs_t e, o;
        int   n;
        for (int k = 0; k < 3; k++)
            drive_cycle(1'b1, 32'(32'h400 + k * 4), 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, e, o);
        ex_valid = 1'b1; ex_taken = 1'b1; ex_target = 32'h800;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checks++; if ({bht_we, flush, f_ready} !== 3'b000 || {bht_clr, init_busy} !== 2'b11 || bht_idx !== 8'd0) begin
            errors++; $display("FAIL mid_reset got we=%b fl=%b rdy=%b clr=%b busy=%b idx=%0d", bht_we, flush, f_ready, bht_clr, init_busy, bht_idx);
        end
        ex_valid = 1'b0; ex_taken = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bht_we !== 1'b0 || flush !== 1'b0) begin
            errors++; $display("FAIL mid_reset_hold got we=%b fl=%b exp 0 0", bht_we, flush);
        end
        rst = 1'b0;
        n = 0;
        while (bht_clr === 1'b1 && n < 300) begin
            n++;
            @(negedge clk);
        end
        checks++; if (n != 256 || init_busy !== 1'b0) begin
            errors++; $display("FAIL mid_reinit got clr_cycles=%0d busy=%b exp 256 0", n, init_busy);
        end
        mq.delete();
        m_flush = 1'b0;
        drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, e, o);
        checks++; if (o.ready !== 1'b1 || o.err !== 1'b1 || o.we !== 1'b0) begin
            errors++; $display("FAIL mid_queue_cleared got rdy=%b err=%b we=%b exp 1 1 0", o.ready, o.err, o.we);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_init();
        test_predict_ok();
        test_mispredict_nt();
        test_mispredict_target();
        test_full();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
